fft_loudness_frame_ctrl: RTL

Frame sequencer for the loudness-detection path. It gates the audio sample stream into the FFT in whole NSamples frames. It then gates the FFT magnitude stream into the peak/loudness finder so that the finder only sees contiguous, complete frames. It collects each frame's peak and produces a debounced "loud" decision with hysteresis and hold. Frames with gaps or timeouts are aborted and counted.

---
 rtl/fft_loudness_frame_ctrl_if.sv | 39 +++
 rtl/fft_loudness_frame_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_loudness_frame_ctrl_if.sv
// Bus interface for the loudness frame sequencer: audio/FFT gating, peak-finder
// handshake, thresholds and the frame-level results.
interface fft_loudness_frame_ctrl_if #(
    parameter int W     = 33,
    parameter int NBits = 10,
    parameter int CW    = 16
);
    logic             enable;
    logic             audio_valid;
    logic             fft_in_valid;
    logic             fft_in_last;
    logic             fft_out_valid;
    logic             mag_valid_out;
    logic             finder_reset;
    logic [W-1:0]     peak;
    logic [NBits-1:0] peak_k;
    logic             peak_valid;
    logic [W-1:0]     th_on;
    logic [W-1:0]     th_off;
    logic [W-1:0]     level;
    logic [NBits-1:0] level_k;
    logic             level_valid;
    logic             loud;
    logic [CW-1:0]    frame_count;
    logic [CW-1:0]    drop_count;
    logic             busy;

    modport slave (
        input  enable, audio_valid, fft_out_valid, peak, peak_k, peak_valid, th_on, th_off,
        output fft_in_valid, fft_in_last, mag_valid_out, finder_reset, level, level_k,
               level_valid, loud, frame_count, drop_count, busy
    );

    modport master (
        output enable, audio_valid, fft_out_valid, peak, peak_k, peak_valid, th_on, th_off,
        input  fft_in_valid, fft_in_last, mag_valid_out, finder_reset, level, level_k,
               level_valid, loud, frame_count, drop_count, busy
    );
endinterface

// File: rtl/fft_loudness_frame_ctrl.sv
// Frame sequencer for the loudness path: gates whole frames into the FFT and the
// peak finder, aborts broken frames and derives a hysteretic, held loud flag.
module fft_loudness_frame_ctrl #(
    parameter int NSamples    = 1024,
    parameter int W           = 33,
    parameter int NBits       = $clog2(NSamples),
    parameter int HOLD_FRAMES = 4,
    parameter int TIMEOUT     = 4096,
    parameter int CW          = 16
) (
    input logic                      clk,
    input logic                      reset,
    fft_loudness_frame_ctrl_if.slave bus
);
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FILL      = 3'd1;
    localparam logic [2:0] S_WAIT_OUT  = 3'd2;
    localparam logic [2:0] S_STREAM    = 3'd3;
    localparam logic [2:0] S_WAIT_PEAK = 3'd4;
    localparam logic [2:0] S_REPORT    = 3'd5;

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int QW = $clog2(HOLD_FRAMES + 1);

    localparam logic [NBits-1:0] LAST_IDX  = NBits'(NSamples - 1);
    localparam logic [TW-1:0]    TMO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [QW-1:0]    HOLD_LAST = QW'(HOLD_FRAMES - 1);
    localparam logic [1:0]       PK_LAST   = 2'd3;

    logic [2:0]       state_q, state_d;
    logic [NBits-1:0] cnt_q, cnt_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic [1:0]       wp_q, wp_d;
    logic [QW-1:0]    quiet_q, quiet_d;
    logic [W-1:0]     pk_q, pk_d;
    logic [NBits-1:0] pk_k_q, pk_k_d;
    logic [W-1:0]     level_q, level_d;
    logic [NBits-1:0] level_k_q, level_k_d;
    logic             level_valid_q, level_valid_d;
    logic             loud_q, loud_d;
    logic [CW-1:0]    frame_q, frame_d;
    logic [CW-1:0]    drop_q, drop_d;
    logic             finder_reset_q, finder_reset_d;

    logic             fft_in_valid_s;
    logic             fft_in_last_s;
    logic             mag_valid_s;
    logic             abort_s;
    logic             go_idle_s;

    // Next-state, datapath and combinational gating for the frame sequencer.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        tmo_d          = tmo_q;
        wp_d           = wp_q;
        quiet_d        = quiet_q;
        pk_d           = pk_q;
        pk_k_d         = pk_k_q;
        level_d        = level_q;
        level_k_d      = level_k_q;
        level_valid_d  = 1'b0;
        loud_d         = loud_q;
        frame_d        = frame_q;
        drop_d         = drop_q;
        finder_reset_d = 1'b0;
        fft_in_valid_s = 1'b0;
        fft_in_last_s  = 1'b0;
        mag_valid_s    = 1'b0;
        abort_s        = 1'b0;
        go_idle_s      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.enable) begin
                    state_d = S_FILL;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FILL: begin
                if (!bus.enable) begin
                    go_idle_s = 1'b1;
                end else if (bus.audio_valid) begin
                    fft_in_valid_s = 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        fft_in_last_s = 1'b1;
                        cnt_d         = '0;
                        tmo_d         = '0;
                        state_d       = S_WAIT_OUT;
                    end else begin
                        cnt_d = cnt_q + NBits'(1);
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_WAIT_OUT: begin
                if (!bus.enable) begin
                    go_idle_s = 1'b1;
                end else if (bus.fft_out_valid) begin
                    // The cycle that leaves WAIT_OUT already carries magnitude 0.
                    mag_valid_s = 1'b1;
                    cnt_d       = NBits'(1);
                    tmo_d       = '0;
                    state_d     = S_STREAM;
                end else if (tmo_q == TMO_LAST) begin
                    abort_s = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_STREAM: begin
                if (!bus.enable) begin
                    go_idle_s = 1'b1;
                end else if (bus.fft_out_valid) begin
                    mag_valid_s = 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = '0;
                        wp_d    = '0;
                        state_d = S_WAIT_PEAK;
                    end else begin
                        cnt_d = cnt_q + NBits'(1);
                    end
                end else begin
                    abort_s = 1'b1;
                end
            end
            S_WAIT_PEAK: begin
                if (!bus.enable) begin
                    go_idle_s = 1'b1;
                end else if (bus.peak_valid) begin
                    pk_d    = bus.peak;
                    pk_k_d  = bus.peak_k;
                    wp_d    = '0;
                    state_d = S_REPORT;
                end else if (wp_q == PK_LAST) begin
                    abort_s = 1'b1;
                end else begin
                    wp_d = wp_q + 2'd1;
                end
            end
            S_REPORT: begin
                level_d       = pk_q;
                level_k_d     = pk_k_q;
                level_valid_d = 1'b1;
                frame_d       = frame_q + CW'(1);
                if (pk_q >= bus.th_on) begin
                    loud_d  = 1'b1;
                    quiet_d = '0;
                end else if (pk_q < bus.th_off) begin
                    if (quiet_q == HOLD_LAST) begin
                        loud_d  = 1'b0;
                        quiet_d = '0;
                    end else begin
                        quiet_d = quiet_q + QW'(1);
                    end
                end else begin
                    quiet_d = '0;
                end
                if (bus.enable) begin
                    state_d = S_FILL;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // An aborted frame also breaks the run of consecutive quiet frames.
        if (abort_s) begin
            state_d        = S_FILL;
            finder_reset_d = 1'b1;
            cnt_d          = '0;
            tmo_d          = '0;
            wp_d           = '0;
            quiet_d        = '0;
            if (drop_q != {CW{1'b1}}) begin
                drop_d = drop_q + CW'(1);
            end else begin
                drop_d = drop_q;
            end
        end else if (go_idle_s) begin
            state_d        = S_IDLE;
            finder_reset_d = 1'b1;
            cnt_d          = '0;
            tmo_d          = '0;
            wp_d           = '0;
        end else begin
            finder_reset_d = finder_reset_d;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            tmo_q          <= '0;
            wp_q           <= '0;
            quiet_q        <= '0;
            pk_q           <= '0;
            pk_k_q         <= '0;
            level_q        <= '0;
            level_k_q      <= '0;
            level_valid_q  <= 1'b0;
            loud_q         <= 1'b0;
            frame_q        <= '0;
            drop_q         <= '0;
            finder_reset_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            tmo_q          <= tmo_d;
            wp_q           <= wp_d;
            quiet_q        <= quiet_d;
            pk_q           <= pk_d;
            pk_k_q         <= pk_k_d;
            level_q        <= level_d;
            level_k_q      <= level_k_d;
            level_valid_q  <= level_valid_d;
            loud_q         <= loud_d;
            frame_q        <= frame_d;
            drop_q         <= drop_d;
            finder_reset_q <= finder_reset_d;
        end
    end

    assign bus.fft_in_valid  = fft_in_valid_s;
    assign bus.fft_in_last   = fft_in_last_s;
    assign bus.mag_valid_out = mag_valid_s;
    assign bus.finder_reset  = finder_reset_q;
    assign bus.level         = level_q;
    assign bus.level_k       = level_k_q;
    assign bus.level_valid   = level_valid_q;
    assign bus.loud          = loud_q;
    assign bus.frame_count   = frame_q;
    assign bus.drop_count    = drop_q;
    assign bus.busy          = (state_q != S_IDLE);
endmodule
